// File: rtl/hif_pkg.sv
// Shared types and constants for the HIF I2C slave: FSM state encoding, bus widths,
// default device address and the 3-input majority helper used by the pin filter.
package hif_pkg;

  localparam int         HIF_BYTE_W           = 8;
  localparam logic [6:0] HIF_DEV_ADDR_DEFAULT = 7'h50;

  typedef enum logic [3:0] {
    HIF_ST_IDLE      = 4'd0,
    HIF_ST_ADDR      = 4'd1,
    HIF_ST_ADDR_ACK  = 4'd2,
    HIF_ST_PTR       = 4'd3,
    HIF_ST_PTR_ACK   = 4'd4,
    HIF_ST_WDATA     = 4'd5,
    HIF_ST_WDATA_ACK = 4'd6,
    HIF_ST_RDATA     = 4'd7,
    HIF_ST_RDATA_ACK = 4'd8,
    HIF_ST_IGNORE    = 4'd9
  } hif_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/hif_i2c_slave_if.sv
// Byte-wide register strobe bus between the HIF I2C slave (master modport)
// and the OTP register bank (slave modport).
interface hif_reg_if;
  import hif_pkg::*;

  logic [HIF_BYTE_W-1:0] reg_addr;
  logic [HIF_BYTE_W-1:0] reg_wdata;
  logic                  reg_wr;
  logic                  reg_rd;
  logic [HIF_BYTE_W-1:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_wr,
    output reg_rd,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_wr,
    input  reg_rd,
    output reg_rdata
  );

endinterface

// File: rtl/hif_pin_sync.sv
// Two-flop synchronizer for one I2C pin, with an optional 3-tap majority filter
// enabled by HIF_GLITCH_FILTER_EN. Provides the synchronized level and its registered copy.
module hif_pin_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic pin_s,
  output logic pin_q
);

  // Flops reset to 1 (bus idle level) so release from reset never looks like START/STOP.
  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], pin};
    end
  end

`ifdef HIF_GLITCH_FILTER_EN
  import hif_pkg::*;

  logic [1:0] taps;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= 2'b11;
    end else begin
      taps <= {taps[0], sync[1]};
    end
  end

  // A level must be present in two of three consecutive samples to pass.
  assign pin_s = maj3(sync[1], taps[0], taps[1]);
`else
  assign pin_s = sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_q <= 1'b1;
    end else begin
      pin_q <= pin_s;
    end
  end

endmodule

// File: rtl/hif_i2c_slave.sv
// HIF I2C slave: decodes START/STOP/address/data, drives the SDA open-drain enable and
// issues register read/write strobes. HIF_GLITCH_FILTER_EN enables the pin majority filter.
module hif_i2c_slave
  import hif_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = HIF_DEV_ADDR_DEFAULT
) (
  input  logic      xtal_clk,
  input  logic      por_rst_n,
  input  logic      hif_scl,
  input  logic      hif_sda_in,
  output logic      hif_sda_oe,
  output logic      hif_idle,
  hif_reg_if.master reg_bus
);

  localparam logic [3:0] S_IDLE      = HIF_ST_IDLE;
  localparam logic [3:0] S_ADDR      = HIF_ST_ADDR;
  localparam logic [3:0] S_ADDR_ACK  = HIF_ST_ADDR_ACK;
  localparam logic [3:0] S_PTR       = HIF_ST_PTR;
  localparam logic [3:0] S_PTR_ACK   = HIF_ST_PTR_ACK;
  localparam logic [3:0] S_WDATA     = HIF_ST_WDATA;
  localparam logic [3:0] S_WDATA_ACK = HIF_ST_WDATA_ACK;
  localparam logic [3:0] S_RDATA     = HIF_ST_RDATA;
  localparam logic [3:0] S_RDATA_ACK = HIF_ST_RDATA_ACK;
  localparam logic [3:0] S_IGNORE    = HIF_ST_IGNORE;

  logic                  scl_s, scl_q, sda_s, sda_q;
  logic                  scl_rise, scl_fall, start_det, stop_det, rx_state;
  logic [3:0]            state;
  logic [2:0]            bit_cnt;
  logic                  byte_done, rw, master_ack, load_pend;
  logic [HIF_BYTE_W-1:0] shift;

  hif_pin_sync u_scl_sync (
    .clk   (xtal_clk),
    .rst_n (por_rst_n),
    .pin   (hif_scl),
    .pin_s (scl_s),
    .pin_q (scl_q)
  );

  hif_pin_sync u_sda_sync (
    .clk   (xtal_clk),
    .rst_n (por_rst_n),
    .pin   (hif_sda_in),
    .pin_s (sda_s),
    .pin_q (sda_q)
  );

  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & sda_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_q & sda_s;
  assign rx_state  = (state == S_ADDR) || (state == S_PTR) || (state == S_WDATA);
  assign hif_idle  = (state == S_IDLE);

  // Bus conditions win over clock edges; bytes complete on the 8th rise and are acted on at the next fall.
  always_ff @(posedge xtal_clk or negedge por_rst_n) begin
    if (!por_rst_n) begin
      state             <= S_IDLE;
      bit_cnt           <= 3'd0;
      byte_done         <= 1'b0;
      rw                <= 1'b0;
      master_ack        <= 1'b0;
      load_pend         <= 1'b0;
      shift             <= '0;
      hif_sda_oe        <= 1'b0;
      reg_bus.reg_addr  <= '0;
      reg_bus.reg_wdata <= '0;
      reg_bus.reg_wr    <= 1'b0;
      reg_bus.reg_rd    <= 1'b0;
    end else begin
      reg_bus.reg_wr <= 1'b0;
      reg_bus.reg_rd <= 1'b0;
      load_pend      <= reg_bus.reg_rd;

      // Read data lands the cycle after reg_rd; its MSB goes straight onto the line.
      if (load_pend && (state == S_RDATA)) begin
        shift      <= reg_bus.reg_rdata;
        hif_sda_oe <= ~reg_bus.reg_rdata[HIF_BYTE_W-1];
      end

      if (start_det) begin
        state      <= S_ADDR;
        bit_cnt    <= 3'd0;
        byte_done  <= 1'b0;
        hif_sda_oe <= 1'b0;
      end else if (stop_det) begin
        state      <= S_IDLE;
        byte_done  <= 1'b0;
        hif_sda_oe <= 1'b0;
      end else if (scl_rise) begin
        if (rx_state || (state == S_RDATA)) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) byte_done <= 1'b1;
        end
        if (rx_state) shift <= {shift[HIF_BYTE_W-2:0], sda_s};
        if (state == S_RDATA_ACK) master_ack <= ~sda_s;
      end else if (scl_fall) begin
        case (state)
          S_ADDR: begin
            if (byte_done) begin
              byte_done <= 1'b0;
              if (shift[7:1] == DEV_ADDR) begin
                rw         <= shift[0];
                state      <= S_ADDR_ACK;
                hif_sda_oe <= 1'b1;
              end else begin
                state <= S_IGNORE;
              end
            end
          end
          S_ADDR_ACK: begin
            hif_sda_oe <= 1'b0;
            bit_cnt    <= 3'd0;
            if (rw) begin
              reg_bus.reg_rd <= 1'b1;
              state          <= S_RDATA;
            end else begin
              state <= S_PTR;
            end
          end
          S_PTR: begin
            if (byte_done) begin
              byte_done        <= 1'b0;
              reg_bus.reg_addr <= shift;
              state            <= S_PTR_ACK;
              hif_sda_oe       <= 1'b1;
            end
          end
          S_PTR_ACK: begin
            hif_sda_oe <= 1'b0;
            state      <= S_WDATA;
          end
          S_WDATA: begin
            if (byte_done) begin
              byte_done         <= 1'b0;
              reg_bus.reg_wdata <= shift;
              reg_bus.reg_wr    <= 1'b1;
              state             <= S_WDATA_ACK;
              hif_sda_oe        <= 1'b1;
            end
          end
          S_WDATA_ACK: begin
            hif_sda_oe       <= 1'b0;
            reg_bus.reg_addr <= reg_bus.reg_addr + 8'd1;
            state            <= S_WDATA;
          end
          S_RDATA: begin
            if (byte_done) begin
              byte_done  <= 1'b0;
              hif_sda_oe <= 1'b0;
              state      <= S_RDATA_ACK;
            end else begin
              shift      <= {shift[HIF_BYTE_W-2:0], 1'b0};
              hif_sda_oe <= ~shift[HIF_BYTE_W-2];
            end
          end
          S_RDATA_ACK: begin
            if (master_ack) begin
              reg_bus.reg_addr <= reg_bus.reg_addr + 8'd1;
              reg_bus.reg_rd   <= 1'b1;
              bit_cnt          <= 3'd0;
              state            <= S_RDATA;
            end else begin
              state <= S_IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hif_i2c_slave.sv
// Bench for hif_i2c_slave: a bit-level I2C master plus a transaction model of expected
// ACKs, register writes and reads; a per-cycle compare process checks the strobe bus.
module tb_hif_i2c_slave;
  import hif_pkg::*;

  localparam logic [6:0] DEV = 7'h50;

  logic xtal_clk  = 1'b0;
  logic por_rst_n = 1'b0;
  logic hif_scl   = 1'b1;
  logic sda_m     = 1'b1;
  logic sda_line;
  logic hif_sda_oe;
  logic hif_idle;

  int vec_count  = 0;
  int miss_count = 0;

  logic [7:0]  bank_mem [256];
  logic [15:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [15:0] obs_wr_q [$];
  bit          quiet = 1'b0;

  hif_reg_if reg_bus ();

  assign sda_line = sda_m & ~hif_sda_oe;

  hif_i2c_slave #(.DEV_ADDR(DEV)) dut (
    .xtal_clk   (xtal_clk),
    .por_rst_n  (por_rst_n),
    .hif_scl    (hif_scl),
    .hif_sda_in (sda_line),
    .hif_sda_oe (hif_sda_oe),
    .hif_idle   (hif_idle),
    .reg_bus    (reg_bus)
  );

  always #5 xtal_clk = ~xtal_clk;

  // Register bank: read data is returned one cycle after the request.
  always @(posedge xtal_clk) begin
    if (reg_bus.reg_rd) reg_bus.reg_rdata <= bank_mem[reg_bus.reg_addr];
  end

  task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Strobe bus is compared against the model's expected write/read queues every cycle.
  always @(negedge xtal_clk) begin
    logic [15:0] e_wr;
    logic [7:0]  e_rd;
    if (por_rst_n) begin
      if (reg_bus.reg_wr || reg_bus.reg_rd)
        check_output("strobe_excl", 16'(reg_bus.reg_wr & reg_bus.reg_rd), 16'h0);
      if (reg_bus.reg_wr) begin
        obs_wr_q.push_back({reg_bus.reg_addr, reg_bus.reg_wdata});
        check_output("wr_pending", 16'(exp_wr_q.size() > 0), 16'h1);
        if (exp_wr_q.size() > 0) begin
          e_wr = exp_wr_q.pop_front();
          check_output("wr_addr_data", {reg_bus.reg_addr, reg_bus.reg_wdata}, e_wr);
        end
      end
      if (reg_bus.reg_rd) begin
        check_output("rd_pending", 16'(exp_rd_q.size() > 0), 16'h1);
        if (exp_rd_q.size() > 0) begin
          e_rd = exp_rd_q.pop_front();
          check_output("rd_addr", 16'(reg_bus.reg_addr), 16'(e_rd));
        end
      end
      if (quiet) check_output("sda_quiet", 16'(hif_sda_oe), 16'h0);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge xtal_clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_cycles(10);
    hif_scl = 1'b1;
    wait_cycles(8);
    sda_m = 1'b0;
    wait_cycles(8);
    hif_scl = 1'b0;
    wait_cycles(2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_cycles(10);
    hif_scl = 1'b1;
    wait_cycles(8);
    sda_m = 1'b1;
    wait_cycles(10);
  endtask

  task automatic i2c_bit(input logic b);
    wait_cycles(3);
    sda_m = b;
    wait_cycles(7);
    hif_scl = 1'b1;
    wait_cycles(10);
    hif_scl = 1'b0;
  endtask

  task automatic get_ack(output bit ack);
    wait_cycles(3);
    sda_m = 1'b1;
    wait_cycles(7);
    hif_scl = 1'b1;
    wait_cycles(5);
    ack = ~sda_line;
    wait_cycles(5);
    hif_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] data, output bit ack);
    for (int i = 7; i >= 0; i--) i2c_bit(data[i]);
    get_ack(ack);
  endtask

  task automatic read_byte(input bit master_ack, output logic [7:0] data);
    data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wait_cycles(3);
      sda_m = 1'b1;
      wait_cycles(7);
      hif_scl = 1'b1;
      wait_cycles(5);
      data = {data[6:0], sda_line};
      wait_cycles(5);
      hif_scl = 1'b0;
    end
    i2c_bit(~master_ack);
  endtask

  function automatic bit model_addr_match(input logic [7:0] addr_byte);
    return addr_byte[7:1] == DEV;
  endfunction

  // One write transaction; the model predicts ACKs and the landing address of each data byte.
  task automatic write_txn(input logic [7:0] addr_byte, input logic [7:0] ptr,
                           input logic [7:0] d0, input logic [7:0] d1, input int ndata);
    bit         ack;
    bit         want;
    logic [7:0] d;
    want = model_addr_match(addr_byte) && !addr_byte[0];
    i2c_start();
    check_output("busy_after_start", 16'(hif_idle), 16'h0);
    write_byte(addr_byte, ack);
    check_output("addr_ack", 16'(ack), 16'(want));
    write_byte(ptr, ack);
    check_output("ptr_ack", 16'(ack), 16'(want));
    for (int i = 0; i < ndata; i++) begin
      d = (i == 0) ? d0 : d1;
      if (want) exp_wr_q.push_back({8'(ptr + i), d});
      write_byte(d, ack);
      check_output("data_ack", 16'(ack), 16'(want));
    end
    i2c_stop();
    check_output("idle_after_stop", 16'(hif_idle), 16'h1);
  endtask

  task automatic apply_stimulus();
    bit         ack;
    logic [7:0] d;
    logic [7:0] model_ptr;
    logic [7:0] glitch_byte;
    bit         want_glitch_ack;

    // Reset values
    por_rst_n = 1'b0;
    wait_cycles(4);
    check_output("rst_sda_oe", 16'(hif_sda_oe), 16'h0);
    check_output("rst_idle", 16'(hif_idle), 16'h1);
    check_output("rst_wr", 16'(reg_bus.reg_wr), 16'h0);
    check_output("rst_rd", 16'(reg_bus.reg_rd), 16'h0);
    check_output("rst_addr", 16'(reg_bus.reg_addr), 16'h0);
    check_output("rst_wdata", 16'(reg_bus.reg_wdata), 16'h0);
    por_rst_n = 1'b1;
    wait_cycles(10);

    // Plain write: pointer 0x10, two data bytes
    $display("[TB] write test");
    write_txn(8'hA0, 8'h10, 8'h5A, 8'hC3, 2);
    check_output("wr_count", 16'(obs_wr_q.size()), 16'd2);
    if (obs_wr_q.size() == 2) begin
      check_output("wr0_literal", obs_wr_q[0], 16'h105A);
      check_output("wr1_literal", obs_wr_q[1], 16'h11C3);
    end
    obs_wr_q.delete();

    // Random read: set pointer, repeated START, read two bytes (ACK then NACK)
    $display("[TB] random read test");
    model_ptr = 8'h20;
    i2c_start();
    write_byte(8'hA0, ack);
    check_output("rd_setup_addr_ack", 16'(ack), 16'h1);
    write_byte(model_ptr, ack);
    check_output("rd_setup_ptr_ack", 16'(ack), 16'h1);
    i2c_start();
    exp_rd_q.push_back(model_ptr);
    exp_rd_q.push_back(8'(model_ptr + 1));
    write_byte(8'hA1, ack);
    check_output("rd_addr_ack", 16'(ack), 16'h1);
    read_byte(1'b1, d);
    check_output("rd_byte0_model", 16'(d), 16'(bank_mem[model_ptr]));
    check_output("rd_byte0_literal", 16'(d), 16'h3C);
    read_byte(1'b0, d);
    check_output("rd_byte1_model", 16'(d), 16'(bank_mem[8'(model_ptr + 1)]));
    check_output("rd_byte1_literal", 16'(d), 16'h7E);
    i2c_stop();
    check_output("rd_idle_after_stop", 16'(hif_idle), 16'h1);
    check_output("rd_ptr_after_nack", 16'(reg_bus.reg_addr), 16'h21);

    // Address mismatch: slave must stay off the bus entirely
    $display("[TB] address mismatch test");
    quiet = 1'b1;
    write_txn(8'hA2, 8'h55, 8'h00, 8'h00, 0);
    quiet = 1'b0;
    check_output("mismatch_no_wr", 16'(obs_wr_q.size()), 16'd0);

    // Pointer wrap
    $display("[TB] pointer wrap test");
    write_txn(8'hA0, 8'hFF, 8'h01, 8'h02, 2);
    check_output("wrap_count", 16'(obs_wr_q.size()), 16'd2);
    if (obs_wr_q.size() == 2) begin
      check_output("wrap0_literal", obs_wr_q[0], 16'hFF01);
      check_output("wrap1_literal", obs_wr_q[1], 16'h0002);
    end
    obs_wr_q.delete();

    // Reset asserted while the slave is ACKing a read address
    $display("[TB] reset mid-transfer test");
    i2c_start();
    d = 8'hA1;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i]);
    wait_cycles(3);
    sda_m = 1'b1;
    wait_cycles(7);
    hif_scl = 1'b1;
    wait_cycles(5);
    check_output("ack_driven", 16'(hif_sda_oe), 16'h1);
    por_rst_n = 1'b0;
    #1;
    check_output("rst_mid_sda_oe", 16'(hif_sda_oe), 16'h0);
    check_output("rst_mid_idle", 16'(hif_idle), 16'h1);
    check_output("rst_mid_addr", 16'(reg_bus.reg_addr), 16'h0);
    wait_cycles(4);
    por_rst_n = 1'b1;
    wait_cycles(10);
    write_txn(8'hA0, 8'h30, 8'h77, 8'h00, 1);
    check_output("post_rst_wr", 16'(obs_wr_q.size()), 16'd1);
    obs_wr_q.delete();

    // One-cycle SCL low pulse inside the first address bit
    $display("[TB] glitch test");
`ifdef HIF_GLITCH_FILTER_EN
    want_glitch_ack = 1'b1;
`else
    want_glitch_ack = 1'b0;
`endif
    glitch_byte = 8'hA0;
    i2c_start();
    wait_cycles(3);
    sda_m = glitch_byte[7];
    wait_cycles(7);
    hif_scl = 1'b1;
    wait_cycles(4);
    hif_scl = 1'b0;
    wait_cycles(1);
    hif_scl = 1'b1;
    wait_cycles(5);
    hif_scl = 1'b0;
    for (int i = 6; i >= 0; i--) i2c_bit(glitch_byte[i]);
    get_ack(ack);
    check_output("glitch_addr_ack", 16'(ack), 16'(want_glitch_ack));
    i2c_stop();
    check_output("glitch_idle", 16'(hif_idle), 16'h1);
    check_output("glitch_no_wr", 16'(obs_wr_q.size()), 16'd0);

    check_output("wr_queue_drained", 16'(exp_wr_q.size()), 16'd0);
    check_output("rd_queue_drained", 16'(exp_rd_q.size()), 16'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) bank_mem[i] = 8'(i) ^ 8'hA5;
    bank_mem[8'h20] = 8'h3C;
    bank_mem[8'h21] = 8'h7E;
    apply_stimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/hif_i2c_slave.md
# hif_i2c_slave

I2C slave protocol engine for the host interface (HIF) of `digtop`. It oversamples the off-chip `hif_scl`/`hif_sda` pins in the `xtal_clk` domain and decodes START, STOP, address and data bytes. It drives the SDA open-drain enable and presents a byte-wide register read/write strobe bus to the downstream OTP register bank. It also produces `hif_idle` for the `hif_idle_feedback` path.

## Interface
- `DEV_ADDR`, 7'h50: 7-bit slave address matched on the bus.
- `xtal_clk`  in  1: system clock; all logic on the rising edge.
- `por_rst_n`  in  1: asynchronous active-low reset. Single clock; asynchronous assert; release is synchronous to `xtal_clk` upstream.
- `hif_scl`  in  1: raw SCL pin, asynchronous to `xtal_clk`.
- `hif_sda_in`  in  1: raw SDA pin, asynchronous to `xtal_clk`.
- `hif_sda_oe`  out  1: 1 pulls SDA low. SDA is never driven high.
- `hif_idle`  out  1: 1 when the FSM is in IDLE.
- `reg_addr`  out  8: register pointer.
- `reg_wdata`  out  8: write data; valid while `reg_wr` = 1.
- `reg_wr`  out  1: single-cycle write strobe.
- `reg_rd`  out  1: single-cycle read request.
- `reg_rdata`  in  8: read data; must be valid the cycle after `reg_rd`.

## Operation
- **Input sampling:** 2-flop synchronizers on SCL and SDA give `scl_s`/`sda_s`. Registered copies give `scl_q`/`sda_q`.
- **Edge and condition detection:**
  - `scl_rise` = `scl_s & ~scl_q`; `scl_fall` = `~scl_s & scl_q`.
  - START = SDA fall while `scl_s` = 1.
  - STOP = SDA rise while `scl_s` = 1.
- **States:** IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- **START** from any state → ADDR. This covers repeated start. Bit counter is cleared and `hif_sda_oe` = 0.
- **STOP** from any state → IDLE with `hif_sda_oe` = 0.
- **Data bits:** shifted in MSB first on `scl_rise`. The bit counter counts 0..7. The 8th `scl_rise` completes the byte.
- **Address byte:**
  - If bits[7:1] = DEV_ADDR, then on the next `scl_fall` go to ADDR_ACK with `hif_sda_oe` = 1.
  - Otherwise go to IGNORE, which waits for START or STOP.
- **ACK release:** in every ACK state, `hif_sda_oe` is released on the `scl_fall` that ends the ACK clock.
- **Write (R/W = 0):**
  - First data byte → PTR, loaded into `reg_addr`; ACK via PTR_ACK.
  - Each further byte → WDATA. `reg_wdata` is loaded and `reg_wr` pulses one cycle on the `scl_fall` entering WDATA_ACK.
  - `reg_addr` increments on the `scl_fall` leaving WDATA_ACK.
- **Read (R/W = 1):**
  - `reg_rd` pulses one cycle on the `scl_fall` entering RDATA, i.e. the end of ADDR_ACK or of a master-ACKed RDATA_ACK.
  - `reg_rdata` is captured into the shift register the next cycle.
  - `hif_sda_oe` = ~shift[7] is updated on each `scl_fall`.
  - After 8 bits → RDATA_ACK with `hif_sda_oe` = 0. SDA is sampled on `scl_rise`:
    - 0 (ACK): `reg_addr`++ and the next byte follows.
    - 1 (NACK): → IGNORE.
- **Pointer wrap:** `reg_addr` wraps 8'hFF → 8'h00.

## Timing
- **Reset values:** `hif_sda_oe` 0, `hif_idle` 1, `reg_wr` 0, `reg_rd` 0, `reg_addr` 8'h00, `reg_wdata` 8'h00, FSM IDLE, bit counter 0.
- **Latency:** pin to `scl_s` is 2 cycles (3 with the filter, see Configuration). The edge detect adds 1 more cycle.
- **SCL period limits:** SCL high and low periods must each be ≥ 6 `xtal_clk` cycles. The `reg_rd`→`reg_rdata` capture (2 cycles) must fit before SDA is needed.
- **Priority:** START/STOP take priority over `scl_rise`/`scl_fall` in the same cycle.
- **Strobes:** `reg_wr` and `reg_rd` are never high in the same cycle.
- **Reset mid-transfer:** everything returns to reset values immediately, and the SDA line is released.

## Configuration
- `HIF_GLITCH_FILTER_EN`
  - **Defined:** a 3-tap majority filter follows each synchronizer. This suppresses 1-cycle pulses and adds 1 cycle of latency.
  - **Undefined:** the synchronizer output is used directly, and 1-cycle glitches are treated as real edges.

## Structure
- **Package `hif_pkg`:** FSM state enum `hif_state_t`, `HIF_DEV_ADDR_DEFAULT` = 7'h50, `HIF_BYTE_W` = 8.
- **Sub-module `hif_pin_sync`:** one instance per pin. Contains the synchronizer and the optional majority filter, and provides the `_s`/`_q` outputs.

## Test plan
- **Write:** START, 0xA0, 0x10, 0x5A, 0xC3, STOP → ACK on all four bytes; `reg_wr` pulses with (0x10, 0x5A) then (0x11, 0xC3); `hif_idle` returns to 1.
- **Random read:** write pointer 0x20, repeated START, 0xA1; model returns 0x3C then 0x7E; master ACKs then NACKs → SDA carries 0x3C, 0x7E; two `reg_rd` pulses at 0x20 and 0x21.
- **Address mismatch:** START, 0xA2, 0x55, STOP → no ACK, no strobes, `hif_sda_oe` stays 0.
- **Pointer wrap:** pointer 0xFF, write 0x01, 0x02 → writes land at 0xFF then 0x00.
- **Reset mid-transfer:** `por_rst_n` low during a read ACK bit → `hif_sda_oe` = 0 and `hif_idle` = 1 at once; the next transaction completes normally.
- **Glitch filter:** 1-cycle SCL low pulse inside a data bit → ignored when `HIF_GLITCH_FILTER_EN` is defined; the bit counter advances when it is undefined.
